// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared PS/2 definitions for the host transmitter and the
// keyboard receiver (keyboard_interface).
//   ps2_state_e    : host-to-device transmit FSM states
//   PS2_DATA_BITS  : data bits per frame
//   PS2_HOST_BITS  : bits the host places on the line after the start bit
//                    (8 data + parity + stop), one per device falling edge
//   PS2_ACK_EDGE   : device falling edge on which the ACK bit is sampled
//   odd_parity()   : PS/2 odd parity bit for a data byte
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam int unsigned PS2_DATA_BITS = 8;
  localparam int unsigned PS2_HOST_BITS = 10;
  localparam int unsigned PS2_ACK_EDGE  = 11;

  // Parity bit that makes the total number of ones (data + parity) odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync -- brings the asynchronous PS/2 clock and data lines into
// the clk domain and flags device clock falling edges.
//   clk_i       : system clock
//   rst_ni      : asynchronous active-low reset (lines read as idle/high)
//   ps2_clk_i   : raw PS/2 clock line
//   ps2_dat_i   : raw PS/2 data line
//   clk_sync_o  : synchronized PS/2 clock
//   dat_sync_o  : synchronized PS/2 data
//   clk_fall_o  : one-cycle pulse, synchronized clock went 1 -> 0
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic clk_sync_o,
  output logic dat_sync_o,
  output logic clk_fall_o
);

  logic [1:0] clk_ff_q;
  logic [1:0] dat_ff_q;
  logic       clk_prev_q;

  // Two-flop synchronizers plus one history flop for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_ff_q   <= 2'b11;
      dat_ff_q   <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_ff_q   <= {clk_ff_q[0], ps2_clk_i};
      dat_ff_q   <= {dat_ff_q[0], ps2_dat_i};
      clk_prev_q <= clk_ff_q[1];
    end
  end

  assign clk_sync_o = clk_ff_q[1];
  assign dat_sync_o = dat_ff_q[1];
  assign clk_fall_o = clk_prev_q & ~clk_ff_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
// Inhibits the bus, issues a request-to-send, shifts out 8 data bits, odd
// parity and stop on the device's falling clock edges, then checks the ACK.
//   clk, resetN        : system clock, asynchronous active-low reset
//   PS2_CLK, PS2_DAT   : sensed PS/2 lines (asynchronous)
//   tx_data, tx_start  : command byte and one-cycle send request
//   ps2_clk_oe/_dat_oe : 1 pulls the corresponding open-drain line low
//   tx_busy            : transfer in progress
//   tx_done, tx_error  : one-cycle result pulses (ACK / NACK or timeout)
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 3150,
  parameter int unsigned TIMEOUT_CYCLES = 63000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  // bit_cnt_q holds the number of falling edges already seen in SEND.
  localparam logic [3:0] LAST_DATA_IDX = 4'(PS2_DATA_BITS - 1);
  localparam logic [3:0] PARITY_IDX    = 4'(PS2_DATA_BITS);

  ps2_state_e       state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             parity_q, parity_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic clk_sync_s;
  logic dat_sync_s;
  logic clk_fall_s;
  logic to_hit_s;

  ps2_line_sync u_sync (
    .clk_i      (clk),
    .rst_ni     (resetN),
    .ps2_clk_i  (PS2_CLK),
    .ps2_dat_i  (PS2_DAT),
    .clk_sync_o (clk_sync_s),
    .dat_sync_o (dat_sync_s),
    .clk_fall_o (clk_fall_s)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      data_q    <= 8'h00;
      parity_q  <= 1'b0;
      inh_cnt_q <= '0;
      bit_cnt_q <= 4'd0;
      to_cnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      inh_cnt_q <= inh_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Next-state logic. Outputs are computed for the next state so the
  // registered lines line up exactly with the state they belong to.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    parity_d  = parity_q;
    inh_cnt_d = inh_cnt_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    dat_oe_d  = dat_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    to_hit_s  = (to_cnt_q == TO_LAST);

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          // Frame is captured here; tx_data may change freely afterwards.
          data_d    = tx_data;
          parity_d  = odd_parity(tx_data);
          inh_cnt_d = '0;
          state_d   = INHIBIT;
        end else begin
          state_d = IDLE;
        end
      end

      INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          state_d = REQ;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end

      REQ: begin
        bit_cnt_d = 4'd0;
        to_cnt_d  = '0;
        state_d   = SEND;
      end

      SEND: begin
        if (clk_fall_s) begin
          to_cnt_d  = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q <= LAST_DATA_IDX) begin
            dat_oe_d = ~data_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == PARITY_IDX) begin
            dat_oe_d = ~parity_q;
          end else begin
            // Stop bit: release the line so the device can drive ACK.
            dat_oe_d = 1'b0;
            state_d  = ACK;
          end
        end else if (to_hit_s) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      ACK: begin
        if (clk_fall_s) begin
          to_cnt_d = '0;
          if (!dat_sync_s) begin
            state_d = WAIT_IDLE;
          end else begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end else if (to_hit_s) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      WAIT_IDLE: begin
        if (clk_sync_s && dat_sync_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (clk_fall_s) begin
          to_cnt_d = '0;
        end else if (to_hit_s) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Data line is pulled only in the last inhibit cycle and in REQ (start
    // bit); SEND/ACK values come from the case above.
    if (state_d == INHIBIT) begin
      dat_oe_d = (inh_cnt_d == INH_LAST);
    end else if (state_d == REQ) begin
      dat_oe_d = 1'b1;
    end else if (state_d == IDLE) begin
      dat_oe_d = 1'b0;
    end else begin
      dat_oe_d = dat_oe_d;
    end

    clk_oe_d = (state_d == INHIBIT);
    busy_d   = (state_d != IDLE);
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_error   = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- directed self-checking bench for ps2_host_tx with a
// small open-drain PS/2 device model. Timing parameters are scaled down so
// the whole run stays short.
module tb_ps2_host_tx;

  localparam int INH  = 40;   // inhibit cycles
  localparam int TO   = 600;  // timeout cycles
  localparam int HALF = 20;   // device clock half period in clk cycles

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error;
  logic       PS2_CLK, PS2_DAT;

  // Wired-AND open-drain bus.
  assign PS2_CLK = dev_clk & ~ps2_clk_oe;
  assign PS2_DAT = dev_dat & ~ps2_dat_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .PS2_CLK    (PS2_CLK),
    .PS2_DAT    (PS2_DAT),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor: inhibit length, pulse counts and protocol sanity.
  int   cyc = 0, run = 0, run_dat = 0, inh_len = 0, inh_dat = 0;
  logic run_last = 1'b0, inh_last = 1'b0, clk_oe_prev = 1'b0;
  int   done_cnt = 0, err_cnt = 0, overlap = 0, busy_pulse = 0;
  int   req_cyc = 0, err_cyc = 0;

  always @(negedge clk) begin
    cyc         <= cyc + 1;
    clk_oe_prev <= ps2_clk_oe;
    if (ps2_clk_oe) begin
      run      <= run + 1;
      run_dat  <= run_dat + (ps2_dat_oe ? 1 : 0);
      run_last <= ps2_dat_oe;
    end else begin
      run     <= 0;
      run_dat <= 0;
      if (clk_oe_prev) begin
        inh_len  <= run;
        inh_dat  <= run_dat;
        inh_last <= run_last;
        req_cyc  <= cyc;
      end
    end
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (tx_done && tx_error) overlap <= overlap + 1;
    if ((tx_done || tx_error) && tx_busy) busy_pulse <= busy_pulse + 1;
  end

  logic [10:0] smp;
  bit          got_req;

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    chk("busy_after_start", 32'(tx_busy), 32'(1));
  endtask

  // Device model: waits for the request-to-send, clocks 11 edges, samples
  // the host bit at the end of each high phase, optionally ACKs on edge 11.
  // Returns right after pulling the clock low on abort_edge (0 = none).
  task automatic dev_frame(input bit ack, input int abort_edge,
                           output logic [10:0] s, output bit rq);
    s  = '1;
    rq = 1'b0;
    for (int i = 0; i < INH + 50 && !rq; i++) begin
      @(negedge clk);
      if (!ps2_clk_oe && ps2_dat_oe && tx_busy) rq = 1'b1;
    end
    if (!rq) return;
    repeat (HALF) @(negedge clk);
    s[0] = PS2_DAT;
    for (int e = 1; e <= 11; e++) begin
      if (e == 11 && ack) begin
        dev_dat = 1'b0;
        repeat (4) @(negedge clk);
      end
      dev_clk = 1'b0;
      if (e == abort_edge) return;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      if (e <= 10) s[e] = PS2_DAT;
    end
    dev_dat = 1'b1;
  endtask

  // Bounded wait for a tx_done or tx_error pulse after the given counts.
  task automatic wait_end(input string tag, input int bound, input int d0, input int e0);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (done_cnt != d0 || err_cnt != e0) seen = 1'b1;
    end
    repeat (3) @(negedge clk);
    chk(tag, 32'(seen), 32'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0, lat;

    // Reset state, lines idle.
    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'({ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error}), 32'(0));
    resetN = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_outputs", 32'({ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error}), 32'(0));
    chk("idle_state", 32'(dut.state_q), 32'(0));

    // 0xED, device ACKs.
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED);
    chk("inhibit_clk_oe", 32'(ps2_clk_oe), 32'(1));
    dev_frame(1'b1, 0, smp, got_req);
    chk("ed_req_seen", 32'(got_req), 32'(1));
    wait_end("ed_end_seen", 4 * TO, d0, e0);
    chk("ed_inhibit_len", 32'(inh_len), 32'(INH));
    chk("ed_inhibit_dat_cycles", 32'(inh_dat), 32'(1));
    chk("ed_inhibit_dat_last", 32'(inh_last), 32'(1));
    chk("ed_start_bit", 32'(smp[0]), 32'(0));
    chk("ed_data", 32'(smp[8:1]), 32'(8'hED));
    chk("ed_parity", 32'(smp[9]), 32'(1));
    chk("ed_stop", 32'(smp[10]), 32'(1));
    chk("ed_done_cnt", 32'(done_cnt - d0), 32'(1));
    chk("ed_err_cnt", 32'(err_cnt - e0), 32'(0));
    chk("ed_busy_after", 32'(tx_busy), 32'(0));

    // 0x07, device NACKs (data held high on edge 11).
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h07);
    dev_frame(1'b0, 0, smp, got_req);
    wait_end("07_end_seen", 4 * TO, d0, e0);
    chk("07_data", 32'(smp[8:1]), 32'(8'h07));
    chk("07_parity", 32'(smp[9]), 32'(0));
    chk("07_err_cnt", 32'(err_cnt - e0), 32'(1));
    chk("07_done_cnt", 32'(done_cnt - d0), 32'(0));
    chk("07_busy_after", 32'(tx_busy), 32'(0));

    // 0xFF, device never clocks -> timeout.
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hFF);
    wait_end("ff_end_seen", INH + 2 * TO, d0, e0);
    lat = err_cyc - req_cyc;
    // tx_error is a registered pulse, so allow it to land one cycle late.
    chk("ff_timeout_latency", 32'((lat == TO) || (lat == TO + 1)), 32'(1));
    chk("ff_err_cnt", 32'(err_cnt - e0), 32'(1));
    chk("ff_done_cnt", 32'(done_cnt - d0), 32'(0));
    chk("ff_oe_released", 32'({ps2_clk_oe, ps2_dat_oe}), 32'(0));
    chk("ff_busy_after", 32'(tx_busy), 32'(0));

    // 0xED again, second start with 0x00 mid-frame must be ignored.
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED);
    fork
      dev_frame(1'b1, 0, smp, got_req);
      begin
        repeat (INH + 150) @(negedge clk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    wait_end("mid_end_seen", 4 * TO, d0, e0);
    chk("mid_data", 32'(smp[8:1]), 32'(8'hED));
    chk("mid_parity", 32'(smp[9]), 32'(1));
    chk("mid_done_cnt", 32'(done_cnt - d0), 32'(1));
    repeat (INH + 20) @(negedge clk);
    chk("mid_no_second_frame", 32'({tx_busy, ps2_clk_oe}), 32'(0));

    // 0xED, reset asserted at device falling edge 5 (host then drives bit4=0).
    start_tx(8'hED);
    dev_frame(1'b1, 5, smp, got_req);
    repeat (6) @(negedge clk);
    chk("abort_bit4_driven", 32'(ps2_dat_oe), 32'(1));
    #2 resetN = 1'b0;
    #1;
    chk("abort_oe_cleared", 32'({ps2_clk_oe, ps2_dat_oe}), 32'(0));
    chk("abort_busy_cleared", 32'(tx_busy), 32'(0));
    chk("abort_state", 32'(dut.state_q), 32'(0));
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    repeat (3) @(negedge clk);

    // 0xF4 after the aborted frame.
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hF4);
    dev_frame(1'b1, 0, smp, got_req);
    wait_end("f4_end_seen", 4 * TO, d0, e0);
    chk("f4_data", 32'(smp[8:1]), 32'(8'hF4));
    chk("f4_parity", 32'(smp[9]), 32'(0));
    chk("f4_done_cnt", 32'(done_cnt - d0), 32'(1));
    chk("f4_err_cnt", 32'(err_cnt - e0), 32'(0));

    // Whole-run protocol sanity.
    chk("done_error_overlap", 32'(overlap), 32'(0));
    chk("busy_during_pulse", 32'(busy_pulse), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
